// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, one partial product per clock.
// Operands are widened by one bit so a single datapath serves both signed and unsigned modes.
module seq_booth_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int EW = WIDTH + 1;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] ITERS = CW'(EW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic signed [AW-1:0] r_a;
  logic signed [AW-1:0] r_m;
  logic [EW-1:0]        r_q;
  logic                 r_qm1;
  logic [CW-1:0]        r_cnt;

  logic                 w_load;
  logic                 w_last;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_a_sh;
  logic [EW-1:0]        w_q_sh;

  // Unsigned operands become non-negative signed values one bit wider.
  function automatic logic [EW-1:0] ext_q(input logic sm, input logic [WIDTH-1:0] x);
    return {sm & x[WIDTH-1], x};
  endfunction

  function automatic logic signed [AW-1:0] ext_m(input logic sm, input logic [WIDTH-1:0] x);
    return {{2{sm & x[WIDTH-1]}}, x};
  endfunction

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
    w_a_sh = {w_sum[AW-1], w_sum[AW-1:1]};
    w_q_sh = {w_sum[0], r_q[EW-1:1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_load      = start;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy  = (r_state == RUN);
  assign valid = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The final iteration's shifted value goes straight into result on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_qm1  <= 1'b0;
      r_cnt  <= '0;
      result <= '0;
    end else if (w_load) begin
      r_a    <= '0;
      r_m    <= ext_m(signed_mode, multiplicand);
      r_q    <= ext_q(signed_mode, multiplier);
      r_qm1  <= 1'b0;
      r_cnt  <= ITERS;
    end else if (r_state == RUN) begin
      r_a    <= w_a_sh;
      r_q    <= w_q_sh;
      r_qm1  <= r_q[0];
      r_cnt  <= r_cnt - CW'(1);
      if (w_last) begin
        result <= {w_a_sh[WIDTH-2:0], w_q_sh};
      end
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed and swept checks of seq_booth_mult at WIDTH=4 against a bench-side product model.
module tb_seq_booth_mult;

  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    int             due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           valid;
  logic [2*W-1:0] result;

  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  logic [2*W-1:0] last_res = '0;
  exp_t           sb[$];
  exp_t           e_mon;

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .valid        (valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge rst) last_res = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] m,
                                           input logic [W-1:0] q);
    longint a;
    longint b;
    logic [63:0] p;
    a = longint'(m);
    b = longint'(q);
    if (sm && m[W-1]) a = a - (longint'(1) << W);
    if (sm && q[W-1]) b = b - (longint'(1) << W);
    p = 64'(a * b);
    return p[2*W-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_valid_excl", {63'd0, busy && valid}, 64'd0);
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {63'd0, valid}, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          chk("result", {56'd0, result}, {56'd0, e_mon.res});
          chk("latency", 64'(cyc), 64'(e_mon.due));
        end
        last_res = result;
      end else begin
        chk("result_hold", {56'd0, result}, {56'd0, last_res});
      end
    end
  end

  // Launches one operation, disturbs inputs while it runs, and checks busy/valid timing.
  task automatic run_op(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] expv);
    exp_t e;
    int   nb;
    signed_mode  = sm;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    e.res = expv;
    e.due = cyc + W + 2;
    sb.push_back(e);
    nb = 0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      if (busy) nb++;
      start        = (i == 1);
      signed_mode  = 1'($urandom);
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
    end
    @(negedge clk);
    chk("busy_cycles", 64'(nb), 64'(W + 1));
    chk("valid_at_latency", {63'd0, valid}, 64'd1);
    chk("busy_in_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [7:0] p;
    int         ka;
    int         kb;
    exp_t       e;

    #1 rst = 1'b1;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_result", {56'd0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed products, including the most-negative operand and mode contrast.
    run_op(1'b1, 4'b0111, 4'b1101, 8'hEB);
    run_op(1'b1, 4'b1000, 4'b1000, 8'h40);
    run_op(1'b1, 4'b1000, 4'b0111, 8'hC8);
    start = 1'b0;
    repeat (3) @(negedge clk);
    run_op(1'b0, 4'b1111, 4'b1111, 8'hE1);
    run_op(1'b0, 4'b1111, 4'b0010, 8'h1E);
    run_op(1'b1, 4'b1111, 4'b0010, 8'hFE);
    start = 1'b0;
    @(negedge clk);

    // start held high: back-to-back operations every W+2 cycles.
    signed_mode  = 1'b0;
    multiplicand = 4'b0011;
    multiplier   = 4'b0011;
    start        = 1'b1;
    for (int j = 0; j < 4; j++) begin
      e.res = 8'h09;
      e.due = cyc + W + 2 + j * (W + 2);
      sb.push_back(e);
    end
    repeat (4 * (W + 2)) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-run with an asynchronous reset.
    signed_mode  = 1'b1;
    multiplicand = 4'b0111;
    multiplier   = 4'b0011;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    chk("rst_async_valid", {63'd0, valid}, 64'd0);
    chk("rst_async_result", {56'd0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(1'b1, 4'b0010, 4'b0011, 8'h06);
    start = 1'b0;
    @(negedge clk);

    // Every operand pair in both modes, permuted order, random idle gaps.
    for (int mode = 0; mode < 2; mode++) begin
      ka = 2 * $urandom_range(0, 127) + 1;
      kb = $urandom_range(0, 255);
      for (int i = 0; i < 256; i++) begin
        p = 8'(i * ka + kb);
        run_op(mode[0], p[7:4], p[3:0], model(mode[0], p[7:4], p[3:0]));
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
